updown_count_checker: RTL and testbench
=======================================

// Module: updown_count_checker
// PURPOSE
//  Receive-side checker for the free-running 8-bit up/down counter stream.
//  - Samples count_in on each count_valid strobe and locks onto the triangle sequence 0..MAX..0.
//  - Once locked, predicts every next value; flags mismatches and reports direction and turnaround events.
//  - Sits beside the counter in the bench/SoC as a self-checking consumer of its count bus.
// PARAMETERS
//  W        8          count bus width
//  MAX      2**W-1     turnaround top value; turnaround bottom is fixed at 0
//  ERR_W    16         width of err_count (saturating)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-low (asserted when rst==0)
//  count_valid  in   1      count_in is a new sample this cycle
//  count_in     in   W      observed counter value
//  locked       out  1      checker is tracking the sequence
//  dir          out  1      1=counting up, 0=counting down (valid when locked)
//  expected     out  W      predicted next sample (valid when locked)
//  err          out  1      one-cycle pulse: locked sample != expected
//  err_count    out  ERR_W  total mismatches, saturates at all-ones
//  peak         out  1      one-cycle pulse: accepted sample == MAX while locked
//  trough       out  1      one-cycle pulse: accepted sample == 0 while locked
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=SYNC0; all outputs 0; expected=0; err_count=0.
//  - All outputs are registered and update on the edge that accepts a sample (latency 1).
//  - Pulses last exactly one cycle. No sample is accepted when count_valid==0; the FSM holds.
//  - SYNC0: on valid, store sample as last.
//      - Sample==0: dir=1, expected=1, go TRACK.
//      - Sample==MAX: dir=0, expected=MAX-1, go TRACK.
//      - Otherwise go SYNC1.
//  - SYNC1: on valid, compare sample s with last.
//      - s==last+1: dir=1, go TRACK.
//      - s==last-1: dir=0, go TRACK.
//      - Otherwise store s as last and stay in SYNC1 (no err).
//      - On entry to TRACK, expected = successor(s, dir).
//  - successor(v, d):
//      - d=1 and v==MAX gives MAX-1 with d->0.
//      - d=0 and v==0 gives 1 with d->1.
//      - Otherwise v+1 (d=1) or v-1 (d=0).
//      - There is no repeat at either turnaround and no wrap.
//  - TRACK (locked=1): on valid, compare sample s with expected.
//      - Match: peak/trough pulse if s==MAX/0; dir and expected update via successor.
//      - Mismatch: err pulse; err_count+1 (saturating); locked=0; store s as last; go SYNC1 (relock from s).
//  - peak and trough are never asserted in the same cycle as err.
//  - Reset mid-operation overrides everything: err_count clears and the FSM returns to SYNC0 on that edge.
//  - All arithmetic is W bits. MAX is treated as an unsigned W-bit value; MAX must be >= 2.
// CONFIGURATION
//  COUNT_CHK_PERIOD_EN: adds output period [W+1:0] and pulse period_vld.
//    - Enabled: counts accepted samples from one locked peak to the next.
//    - period and period_vld update at each peak after the first since lock; expected value is 2*MAX.
//    - Loss of lock clears the internal count and discards the pending measurement.
//    - Reset clears period and period_vld to 0.
//  Undefined: the ports are absent and there is no period logic.
// TESTING
//  - Reset then samples 0,1,2...: locked=1 after sample 0; expected=2 after sample 1; no err over 600 samples.
//  - Top turnaround: samples 253,254,255,254: locked after the 254 (SYNC1 path); peak pulse on 255; dir 1->0; no err.
//  - Glitch: locked at 10 going up, inject 40:
//      - err pulse and err_count=1 on 40; locked=0.
//      - Then 41 relocks dir=1; expected=42.
//  - Gaps and saturation:
//      - count_valid low for 7 cycles between samples: no state or output change.
//      - Force 70000 mismatches: err_count holds at 65535.
//  - Reset mid-run: rst=0 for 1 cycle while locked with err_count=3: next edge gives locked=0 and err_count=0; sample 255 relocks dir=0.
//  - COUNT_CHK_PERIOD_EN defined: run two full triangles: period=510 with period_vld pulse at the second peak.

Source files
------------

// File: rtl/updown_count_checker_if.sv
// Count bus carrying the up/down counter samples into the checker.
// Master drives the strobe and value; slave observes them.
interface updown_count_checker_if #(
   parameter int W = 8
);
   logic         count_valid;
   logic [W-1:0] count_in;

   modport master (output count_valid, output count_in);
   modport slave  (input  count_valid, input  count_in);
endinterface

// File: rtl/updown_count_checker.sv
// Receive-side checker locking onto the 0..MAX..0 triangle count stream.
// Optional COUNT_CHK_PERIOD_EN adds peak-to-peak period measurement.
module updown_count_checker #(
   parameter int          W     = 8,
   parameter int unsigned MAX   = 2**W-1,
   parameter int          ERR_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   updown_count_checker_if.slave i_cnt,
   output logic                 locked,
   output logic                 dir,
   output logic [W-1:0]         expected,
   output logic                 err,
   output logic [ERR_W-1:0]     err_count,
   output logic                 peak,
   output logic                 trough
`ifdef COUNT_CHK_PERIOD_EN
   ,
   output logic [W+1:0]         period,
   output logic                 period_vld
`endif
);

   localparam logic [W-1:0] L_MAX = W'(MAX);
   localparam logic [W-1:0] L_ONE = W'(1);

   typedef enum logic [1:0] {SYNC0, SYNC1, TRACK} state_t;

   state_t           r_state;
   logic [W-1:0]     r_last;
   logic [W-1:0]     r_exp;
   logic             r_dir;
   logic             r_locked;
   logic             r_err;
   logic             r_peak;
   logic             r_trough;
   logic [ERR_W-1:0] r_errcnt;

   // {next_dir, next_value}; bounces at 0 and MAX without repeating
   function automatic logic [W:0] f_succ(input logic [W-1:0] v,
                                         input logic d);
      logic [W:0] res;
      if (d && v == L_MAX)      res = {1'b0, L_MAX - L_ONE};
      else if (!d && v == '0)   res = {1'b1, L_ONE};
      else if (d)               res = {1'b1, v + L_ONE};
      else                      res = {1'b0, v - L_ONE};
      return res;
   endfunction

   logic [W-1:0] w_s;
   logic [W:0]   w_succ_up;
   logic [W:0]   w_succ_dn;
   logic [W:0]   w_succ_trk;

   assign w_s        = i_cnt.count_in;
   assign w_succ_up  = f_succ(w_s, 1'b1);
   assign w_succ_dn  = f_succ(w_s, 1'b0);
   assign w_succ_trk = f_succ(w_s, r_dir);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= SYNC0;
         r_last   <= '0;
         r_exp    <= '0;
         r_dir    <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
         r_peak   <= 1'b0;
         r_trough <= 1'b0;
         r_errcnt <= '0;
      end else begin
         r_err    <= 1'b0;
         r_peak   <= 1'b0;
         r_trough <= 1'b0;
         if (i_cnt.count_valid) begin
            unique case (r_state)
               SYNC0: begin
                  r_last <= w_s;
                  if (w_s == '0) begin
                     r_dir    <= 1'b1;
                     r_exp    <= L_ONE;
                     r_locked <= 1'b1;
                     r_state  <= TRACK;
                  end else if (w_s == L_MAX) begin
                     r_dir    <= 1'b0;
                     r_exp    <= L_MAX - L_ONE;
                     r_locked <= 1'b1;
                     r_state  <= TRACK;
                  end else begin
                     r_state  <= SYNC1;
                  end
               end
               SYNC1: begin
                  if (w_s == r_last + L_ONE) begin
                     {r_dir, r_exp} <= w_succ_up;
                     r_locked       <= 1'b1;
                     r_state        <= TRACK;
                  end else if (w_s == r_last - L_ONE) begin
                     {r_dir, r_exp} <= w_succ_dn;
                     r_locked       <= 1'b1;
                     r_state        <= TRACK;
                  end else begin
                     r_last <= w_s;
                  end
               end
               TRACK: begin
                  if (w_s == r_exp) begin
                     {r_dir, r_exp} <= w_succ_trk;
                     r_peak         <= (w_s == L_MAX);
                     r_trough       <= (w_s == '0);
                  end else begin
                     r_err    <= 1'b1;
                     if (r_errcnt != '1)
                        r_errcnt <= r_errcnt + ERR_W'(1);
                     r_locked <= 1'b0;
                     r_last   <= w_s;
                     r_state  <= SYNC1;
                  end
               end
               default: r_state <= SYNC0;
            endcase
         end
      end
   end

   assign locked    = r_locked;
   assign dir       = r_dir;
   assign expected  = r_exp;
   assign err       = r_err;
   assign err_count = r_errcnt;
   assign peak      = r_peak;
   assign trough    = r_trough;

`ifdef COUNT_CHK_PERIOD_EN
   logic         w_match;
   logic [W+1:0] r_pcnt;
   logic         r_pseen;
   logic [W+1:0] r_period;
   logic         r_pvld;

   assign w_match = (r_state == TRACK) && (w_s == r_exp);

   // any accepted sample that is not a locked match drops the measurement
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pcnt   <= '0;
         r_pseen  <= 1'b0;
         r_period <= '0;
         r_pvld   <= 1'b0;
      end else begin
         r_pvld <= 1'b0;
         if (i_cnt.count_valid) begin
            if (w_match) begin
               if (w_s == L_MAX) begin
                  if (r_pseen) begin
                     r_period <= r_pcnt + (W+2)'(1);
                     r_pvld   <= 1'b1;
                  end
                  r_pcnt  <= '0;
                  r_pseen <= 1'b1;
               end else begin
                  r_pcnt <= r_pcnt + (W+2)'(1);
               end
            end else begin
               r_pcnt  <= '0;
               r_pseen <= 1'b0;
            end
         end
      end
   end

   assign period     = r_period;
   assign period_vld = r_pvld;
`endif

endmodule

// File: tb/tb_updown_count_checker.sv
// Directed bench for updown_count_checker.
// Define COUNT_CHK_PERIOD_EN to also exercise the period output.
module tb_updown_count_checker;

   localparam int W     = 8;
   localparam int ERR_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             locked;
   logic             dir;
   logic [W-1:0]     expected;
   logic             err;
   logic [ERR_W-1:0] err_count;
   logic             peak;
   logic             trough;
`ifdef COUNT_CHK_PERIOD_EN
   logic [W+1:0]     period;
   logic             period_vld;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   updown_count_checker_if #(.W(W)) bus ();

   updown_count_checker #(
      .W     (W),
      .ERR_W (ERR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_cnt      (bus),
      .locked     (locked),
      .dir        (dir),
      .expected   (expected),
      .err        (err),
      .err_count  (err_count),
      .peak       (peak),
      .trough     (trough)
`ifdef COUNT_CHK_PERIOD_EN
      ,
      .period     (period),
      .period_vld (period_vld)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic reset_cyc();
      @(negedge clk);
      rst = 1'b0;
      bus.count_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      @(negedge clk);
      rst = 1'b1;
      bus.count_valid = 1'b1;
      bus.count_in = W'(v);
      @(posedge clk);
      #1;
      bus.count_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b1;
         bus.count_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int tri_v(input int i);
      int m;
      m = i % 510;
      return (m <= 255) ? m : 510 - m;
   endfunction

   initial begin
      int errs;
      int pk;
      int tr;
      bus.count_valid = 1'b0;
      bus.count_in = '0;

      reset_cyc();
      chk("rst_locked", 32'(locked), 0);
      chk("rst_dir", 32'(dir), 0);
      chk("rst_exp", 32'(expected), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_cnt", 32'(err_count), 0);
      chk("rst_peak", 32'(peak), 0);
      chk("rst_trough", 32'(trough), 0);

      send(0);
      chk("lock0", 32'(locked), 1);
      chk("lock0_dir", 32'(dir), 1);
      chk("lock0_exp", 32'(expected), 1);
      send(1);
      chk("s1_exp", 32'(expected), 2);
      errs = 0; pk = 0; tr = 0;
      for (int i = 2; i < 600; i++) begin
         send(tri_v(i));
         if (err) errs++;
         if (peak) pk++;
         if (trough) tr++;
         chk("run_exp", 32'(expected), tri_v(i + 1));
      end
      chk("run_errs", errs, 0);
      chk("run_cnt", 32'(err_count), 0);
      chk("run_peaks", pk, 1);
      chk("run_troughs", tr, 1);
      chk("run_locked", 32'(locked), 1);

      reset_cyc();
      send(253);
      chk("top_nolock", 32'(locked), 0);
      send(254);
      chk("top_lock", 32'(locked), 1);
      chk("top_dir_up", 32'(dir), 1);
      chk("top_exp255", 32'(expected), 255);
      send(255);
      chk("top_peak", 32'(peak), 1);
      chk("top_dir_dn", 32'(dir), 0);
      chk("top_exp254", 32'(expected), 254);
      chk("top_err", 32'(err), 0);
      send(254);
      chk("top_peak_off", 32'(peak), 0);
      chk("top_exp253", 32'(expected), 253);
      chk("top_err2", 32'(err), 0);

      reset_cyc();
      for (int v = 0; v <= 10; v++) send(v);
      chk("gl_locked", 32'(locked), 1);
      chk("gl_exp", 32'(expected), 11);
      send(40);
      chk("gl_err", 32'(err), 1);
      chk("gl_cnt", 32'(err_count), 1);
      chk("gl_unlock", 32'(locked), 0);
      chk("gl_nopeak", 32'(peak | trough), 0);
      send(41);
      chk("gl_relock", 32'(locked), 1);
      chk("gl_dir", 32'(dir), 1);
      chk("gl_exp42", 32'(expected), 42);
      chk("gl_err_off", 32'(err), 0);

      idle(7);
      chk("gap_locked", 32'(locked), 1);
      chk("gap_exp", 32'(expected), 42);
      chk("gap_cnt", 32'(err_count), 1);
      chk("gap_err", 32'(err), 0);
      send(42);
      chk("gap_next", 32'(expected), 43);
      chk("gap_next_err", 32'(err), 0);

      send(100);
      chk("mr_cnt2", 32'(err_count), 2);
      send(101);
      send(200);
      send(201);
      chk("mr_cnt3", 32'(err_count), 3);
      chk("mr_locked", 32'(locked), 1);
      reset_cyc();
      chk("mr_unlock", 32'(locked), 0);
      chk("mr_cnt0", 32'(err_count), 0);
      send(255);
      chk("mr_relock", 32'(locked), 1);
      chk("mr_dir", 32'(dir), 0);
      chk("mr_exp", 32'(expected), 254);

      reset_cyc();
      send(10);
      for (int k = 1; k <= 1100; k++) begin
         send(11);
         send(10);
         if (k == 1022) chk("sat_pre", 32'(err_count), 1022);
         if (k == 1023) chk("sat_hit", 32'(err_count), 1023);
      end
      chk("sat_hold", 32'(err_count), 1023);
      chk("sat_err", 32'(err), 1);
      chk("sat_unlock", 32'(locked), 0);

`ifdef COUNT_CHK_PERIOD_EN
      reset_cyc();
      chk("per_rst", 32'(period), 0);
      pk = 0;
      for (int i = 0; i <= 1020; i++) begin
         send(tri_v(i));
         if (i == 255) chk("per_first", 32'(period_vld), 0);
         if (period_vld) begin
            pk++;
            chk("per_val", 32'(period), 510);
            chk("per_at", i, 765);
         end
      end
      chk("per_n", pk, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
